// File: rtl/host_arbiter.sv
// rtl/host_arbiter.sv - round-robin multi-host bus arbiter with hold limit, lock and read-return routing
module host_arbiter #(
  parameter int NR_HOSTS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_HOSTS-1:0]            host_req_i,
  input  logic [NR_HOSTS-1:0]            host_lock_i,
  input  logic [NR_HOSTS-1:0]            host_we_i,
  input  logic [NR_HOSTS*ADDR_WIDTH-1:0] host_addr_i,
  input  logic [NR_HOSTS*DATA_WIDTH-1:0] host_wdata_i,
  output logic [NR_HOSTS-1:0]            host_gnt_o,
  output logic [NR_HOSTS-1:0]            host_rvalid_o,
  output logic [DATA_WIDTH-1:0]          host_rdata_o,
  output logic                           dev_req_o,
  output logic                           dev_we_o,
  output logic [ADDR_WIDTH-1:0]          dev_addr_o,
  output logic [DATA_WIDTH-1:0]          dev_wdata_o,
  input  logic [DATA_WIDTH-1:0]          dev_rdata_i,
  output logic [2:0]                     owner_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0]          HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [2:0]          LAST_HOST  = 3'(NR_HOSTS - 1);
  localparam logic [NR_HOSTS-1:0] HOST0      = {{(NR_HOSTS-1){1'b0}}, 1'b1};

  state_t              state, next_state;
  logic [2:0]          owner, next_owner, last_owner, next_last_owner;
  logic [7:0]          hold, next_hold;
  logic [NR_HOSTS-1:0] owner_oh, others, next_gnt, next_rvalid;
  logic                own_req, own_lock, own_we, transfer, leave;

  // First requester strictly after prev in circular order; prev itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [2:0] prev, input logic [NR_HOSTS-1:0] req);
    logic [NR_HOSTS-1:0] rot;
    int                  idx;
    rr_pick = prev;
    for (int i = NR_HOSTS; i >= 1; i--) begin
      idx = (int'(prev) + i) % NR_HOSTS;
      rot = req >> idx;
      if (rot[0]) rr_pick = 3'(idx);
    end
  endfunction

  assign owner_oh = HOST0 << owner;
  assign others   = host_req_i & ~owner_oh;
  assign own_req  = |(host_req_i & owner_oh);
  assign own_lock = |(host_lock_i & owner_oh);
  assign own_we   = |(host_we_i & owner_oh);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      owner         <= '0;
      last_owner    <= LAST_HOST;
      hold          <= '0;
      host_gnt_o    <= '0;
      host_rvalid_o <= '0;
    end else begin
      state         <= next_state;
      owner         <= next_owner;
      last_owner    <= next_last_owner;
      hold          <= next_hold;
      host_gnt_o    <= next_gnt;
      host_rvalid_o <= next_rvalid;
    end
  end

  always_comb begin
    next_state      = state;
    next_owner      = owner;
    next_last_owner = last_owner;
    next_hold       = hold;
    leave           = 1'b0;
    transfer        = (state == GRANT) && own_req;
    if (transfer && hold != 8'hFF) next_hold = hold + 8'd1;
    if (state == IDLE) begin
      if (|host_req_i) begin
        next_owner = rr_pick(last_owner, host_req_i);
        next_hold  = '0;
        next_state = GRANT;
      end
    end else begin
      // The limit counts the transfer happening this cycle, so a slot is exactly MAX_HOLD cycles.
      leave = !own_req || (next_hold >= HOLD_LIMIT && !own_lock && |others);
      if (leave) begin
        next_last_owner = owner;
        if (|others) begin
          next_owner = rr_pick(owner, host_req_i);
          next_hold  = '0;
        end else begin
          next_state = IDLE;
        end
      end
    end
    next_gnt    = (next_state == GRANT) ? (HOST0 << next_owner) : '0;
    next_rvalid = (transfer && !own_we) ? owner_oh : '0;
  end

  always_comb begin
    dev_req_o   = transfer;
    dev_we_o    = (state == GRANT) && own_we;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    for (int h = 0; h < NR_HOSTS; h++) begin
      if (owner == 3'(h)) begin
        dev_addr_o  = host_addr_i[h*ADDR_WIDTH +: ADDR_WIDTH];
        dev_wdata_o = host_wdata_i[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // Read data is routed in the cycle the device returns it, tagged by the registered strobe.
    host_rdata_o = (|host_rvalid_o) ? dev_rdata_i : '0;
    owner_o      = owner;
  end

endmodule

// File: tb/tb_host_arbiter.sv
// tb/tb_host_arbiter.sv - randomized and directed self-checking bench for host_arbiter
module tb_host_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0, lock = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] dev_rdata = 32'h0000_1234;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata, dev_wdata;
  logic          dev_req, dev_we;
  logic [AW-1:0] dev_addr;
  logic [2:0]    owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  host_arbiter #(.NR_HOSTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(req), .host_lock_i(lock), .host_we_i(we),
    .host_addr_i(addr), .host_wdata_i(wdata),
    .host_gnt_o(gnt), .host_rvalid_o(rvalid), .host_rdata_o(rdata),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
    .dev_rdata_i(dev_rdata), .owner_o(owner)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Reference: who owns the bus, how many transfers in this tenure, which host a read is owed to.
  bit m_valid = 0;
  bit m_grant = 0;
  int m_owner = 0, m_last = N - 1, m_tenure = 0, m_rd = -1;

  function automatic int next_in_turn(input int after, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (bit_at(r, (after + k) % N)) return (after + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    bit mine, rivals;
    if (!rst) begin
      m_valid = 1; m_grant = 0; m_owner = 0; m_last = N - 1; m_tenure = 0; m_rd = -1;
    end else if (m_valid) begin
      m_rd = -1;
      if (!m_grant) begin
        if (req != '0) begin
          m_owner = next_in_turn(m_last, req); m_tenure = 0; m_grant = 1;
        end
      end else begin
        mine   = bit_at(req, m_owner);
        rivals = 0;
        for (int h = 0; h < N; h++) if (h != m_owner && bit_at(req, h)) rivals = 1;
        if (mine) begin
          m_tenure = (m_tenure < 255) ? m_tenure + 1 : 255;
          if (!bit_at(we, m_owner)) m_rd = m_owner;
        end
        if (!mine || (m_tenure >= MH && !bit_at(lock, m_owner) && rivals)) begin
          m_last = m_owner;
          if (rivals) begin m_owner = next_in_turn(m_last, req); m_tenure = 0; end
          else m_grant = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic compare();
    logic [N-1:0] eg, er;
    bit           ereq;
    eg   = m_grant ? (N'(1) << m_owner) : '0;
    er   = (m_rd >= 0) ? (N'(1) << m_rd) : '0;
    ereq = m_grant && bit_at(req, m_owner);
    chk("gnt", gnt, eg);
    chk("rvalid", rvalid, er);
    chk("rdata", rdata, (m_rd >= 0) ? dev_rdata : '0);
    chk("owner", owner, 3'(m_owner));
    chk("dev_req", dev_req, ereq);
    chk("dev_we", dev_we, m_grant && bit_at(we, m_owner));
    if (ereq) begin
      chk("dev_addr", dev_addr, addr[m_owner*AW +: AW]);
      chk("dev_wdata", dev_wdata, wdata[m_owner*DW +: DW]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (m_valid) compare();
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reset_to(input logic [N-1:0] r);
    rst = 1'b0; req = r;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    #3;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_owner", owner, 3'd0);
    chk("rst_dev_req", dev_req, 1'b0);

    // Both request from reset; host 0 first, host 1 right after host 0 drops.
    reset_to(2'b11);
    #3 chk("first_win_h0", gnt, 2'b01);
    req = 2'b10;
    cyc();
    #3 chk("handoff_h1", gnt, 2'b10);

    // Continuous contention: 4-cycle alternating slots.
    cyc();
    reset_to(2'b11);
    for (int i = 0; i < 16; i++) begin
      #3 chk("slot_rotation", gnt, ((i / 4) % 2) ? 2'b10 : 2'b01);
      cyc();
    end

    // Lock keeps host 0 well past the hold limit.
    lock = 2'b01;
    reset_to(2'b11);
    for (int i = 0; i < 24; i++) begin
      #3 chk("locked_h0", gnt, 2'b01);
      cyc();
    end
    lock = 2'b00;
    cyc();
    #3 chk("unlock_to_h1", gnt, 2'b10);

    // Host 1 alone keeps the grant beyond MAX_HOLD, then a read crosses an ownership switch.
    we = 2'b10;
    reset_to(2'b10);
    for (int i = 0; i < 6; i++) begin
      #3 chk("sole_keeps", gnt, 2'b10);
      cyc();
    end
    req = 2'b11; we = 2'b00; addr[AW +: AW] = 32'h0000_0100;
    #3 chk("read_addr", dev_addr, 32'h0000_0100);
    cyc();
    dev_rdata = 32'hDEAD_BEEF;
    #3;
    chk("read_rvalid", rvalid, 2'b10);
    chk("read_rdata", rdata, 32'hDEAD_BEEF);
    chk("read_switch", gnt, 2'b01);

    // Move ownership to host 1 (last_owner=0), then reset with a read in flight.
    req = 2'b10;
    cyc();
    #3 chk("pre_rst_h1", gnt, 2'b10);
    rst = 1'b0;
    cyc();
    #3;
    chk("rst_mid_gnt", gnt, 2'b00);
    chk("rst_mid_rvalid", rvalid, 2'b00);
    chk("rst_mid_rdata", rdata, 32'h0);
    req = 2'b11; rst = 1'b1;
    cyc();
    #3 chk("post_rst_h0", gnt, 2'b01);

    // Single host console write.
    cyc();
    we = 2'b01; addr[0 +: AW] = 32'h0020_0000;
    reset_to(2'b01);
    #3;
    chk("wr_dev_we", dev_we, 1'b1);
    chk("wr_dev_addr", dev_addr, 32'h0020_0000);
    cyc();
    #3 chk("wr_no_rvalid", rvalid, 2'b00);

    for (int c = 0; c < 4000; c++) begin
      cyc();
      for (int h = 0; h < N; h++) begin
        req[h]  = ($urandom_range(0, 9) < 7);
        lock[h] = ($urandom_range(0, 9) < 2);
        we[h]   = $urandom_range(0, 1);
        addr[h*AW +: AW]  = $urandom;
        wdata[h*DW +: DW] = $urandom;
      end
      dev_rdata = $urandom;
      rst = ($urandom_range(0, 199) != 0);
    end
    rst = 1'b1;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
